// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the inter-stage pipeline registers of the 5-stage
//   MIPS core.
//   - DATA_W_DEFAULT : default width of one payload lane.
//   - NOP_INSTR      : instruction word used as the bubble / reset payload.
//   - LANE_*         : lane index of each payload word on the stage bus.
//   - slot_op_e      : operation applied to one storage slot on a clock edge.
//   - lane_lsb()     : bit offset of a lane on the packed payload bus.
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int unsigned LANE_INSTR = 0;
    localparam int unsigned LANE_PC    = 1;
    localparam int unsigned LANE_PC4   = 2;

    // HOLD keeps the slot, LOAD captures new data, DROP releases the entry
    // but keeps the data bits, CLEAR empties it and restores the reset payload.
    typedef enum logic [1:0] {
        SLOT_HOLD  = 2'd0,
        SLOT_LOAD  = 2'd1,
        SLOT_DROP  = 2'd2,
        SLOT_CLEAR = 2'd3
    } slot_op_e;

    // Bit offset of lane 'lane' on a bus of 'width'-bit lanes.
    function automatic int unsigned lane_lsb(input int unsigned lane,
                                             input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// ---------------------------------------------------------------------------
// pipe_stage_slot
//   One storage entry of a pipeline stage: a valid bit plus a W-bit payload.
//   The stage controller selects the per-edge operation (hold/load/drop/clear).
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset (empty, RESET_VAL payload)
//   op         in   operation applied on the next clock edge
//   load_data  in   payload captured on SLOT_LOAD
//   valid      out  slot holds a payload
//   data       out  stored payload
// ---------------------------------------------------------------------------
module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter int unsigned     W         = 32,
    parameter logic [W-1:0]    RESET_VAL = {W{1'b0}}
) (
    input  logic          clk,
    input  logic          reset,
    input  slot_op_e      op,
    input  logic [W-1:0]  load_data,
    output logic          valid,
    output logic [W-1:0]  data
);

    logic          valid_d;
    logic          valid_q;
    logic [W-1:0]  data_d;
    logic [W-1:0]  data_q;

    // Next-state selection for the slot.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        case (op)
            SLOT_HOLD: begin
                valid_d = valid_q;
                data_d  = data_q;
            end
            SLOT_LOAD: begin
                valid_d = 1'b1;
                data_d  = load_data;
            end
            SLOT_DROP: begin
                valid_d = 1'b0;
                data_d  = data_q;
            end
            SLOT_CLEAR: begin
                valid_d = 1'b0;
                data_d  = RESET_VAL;
            end
            default: begin
                valid_d = valid_q;
                data_d  = data_q;
            end
        endcase
    end

    // Slot state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Inter-stage pipeline register (F/D, D/E, E/M, M/W) carrying LANES payload
//   words with a valid/ready handshake, hazard stall, flush (bubble insert)
//   and a saturating stall-cycle counter.
//   Optional macro PIPE_STAGE_SKID_EN adds a one-entry skid slot so that
//   in_ready no longer depends combinationally on out_ready (capacity 2).
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   in_valid      in   upstream has a payload
//   in_ready      out  stage accepts this cycle
//   in_data       in   upstream payload, lane i = [i*DATA_W +: DATA_W]
//   stall         in   hazard freeze: no accept, no release
//   flush         in   discard content, insert bubble
//   out_valid     out  stage holds a valid payload
//   out_ready     in   downstream consumes
//   out_data      out  registered payload
//   cnt_clr       in   synchronous clear of stall_cycles
//   stall_cycles  out  saturating count of stalled cycles
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        DATA_W    = DATA_W_DEFAULT,
    parameter int unsigned        LANES     = 3,
    parameter logic [DATA_W-1:0]  RESET_VAL = DATA_W'(NOP_INSTR),
    parameter int unsigned        CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DATA_W-1:0]  in_data,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*DATA_W-1:0]  out_data,
    input  logic                     cnt_clr,
    output logic [CNT_W-1:0]         stall_cycles
);

    localparam int unsigned              BUS_W       = LANES * DATA_W;
    localparam logic [BUS_W-1:0]         RST_PAYLOAD = {LANES{RESET_VAL}};
    localparam logic [CNT_W-1:0]         CNT_MAX     = {CNT_W{1'b1}};

    logic              in_ready_s;
    logic              in_fire_s;
    logic              out_fire_s;
    slot_op_e          main_op_s;
    logic [BUS_W-1:0]  main_load_data_s;
    logic              main_valid_s;
    logic [BUS_W-1:0]  main_data_s;

    logic [CNT_W-1:0]  stall_cycles_d;
    logic [CNT_W-1:0]  stall_cycles_q;

    assign in_fire_s  = in_valid & in_ready_s;
    // A stall also blocks the downstream release.
    assign out_fire_s = main_valid_s & out_ready & ~stall;

    pipe_stage_slot #(
        .W         (BUS_W),
        .RESET_VAL (RST_PAYLOAD)
    ) u_main (
        .clk       (clk),
        .reset     (reset),
        .op        (main_op_s),
        .load_data (main_load_data_s),
        .valid     (main_valid_s),
        .data      (main_data_s)
    );

`ifdef PIPE_STAGE_SKID_EN

    slot_op_e          skid_op_s;
    logic              skid_valid_s;
    logic [BUS_W-1:0]  skid_data_s;

    pipe_stage_slot #(
        .W         (BUS_W),
        .RESET_VAL (RST_PAYLOAD)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .op        (skid_op_s),
        .load_data (in_data),
        .valid     (skid_valid_s),
        .data      (skid_data_s)
    );

    // Handshake control with skid: ready only looks at the skid flop, so the
    // out_ready -> in_ready path is broken. The skid is only ever occupied
    // while the main entry is occupied, which keeps FIFO order.
    always_comb begin
        in_ready_s       = ~flush & ~stall & ~skid_valid_s;
        main_op_s        = SLOT_HOLD;
        main_load_data_s = in_data;
        skid_op_s        = SLOT_HOLD;
        if (flush) begin
            main_op_s = SLOT_CLEAR;
            skid_op_s = SLOT_CLEAR;
        end else if (stall) begin
            main_op_s = SLOT_HOLD;
            skid_op_s = SLOT_HOLD;
        end else if (skid_valid_s) begin
            if (out_fire_s) begin
                // Older skid word advances into the main entry.
                main_op_s        = SLOT_LOAD;
                main_load_data_s = skid_data_s;
                skid_op_s        = SLOT_DROP;
            end else begin
                main_op_s = SLOT_HOLD;
                skid_op_s = SLOT_HOLD;
            end
        end else if (in_fire_s) begin
            if (~main_valid_s | out_fire_s) begin
                main_op_s = SLOT_LOAD;
                skid_op_s = SLOT_HOLD;
            end else begin
                main_op_s = SLOT_HOLD;
                skid_op_s = SLOT_LOAD;
            end
        end else if (out_fire_s) begin
            main_op_s = SLOT_DROP;
            skid_op_s = SLOT_HOLD;
        end else begin
            main_op_s = SLOT_HOLD;
            skid_op_s = SLOT_HOLD;
        end
    end

`else

    // Handshake control without skid: a full stage accepts only when it is
    // being drained in the same cycle (combinational out_ready path).
    always_comb begin
        in_ready_s       = ~flush & ~stall & (~main_valid_s | out_ready);
        main_op_s        = SLOT_HOLD;
        main_load_data_s = in_data;
        if (flush) begin
            main_op_s = SLOT_CLEAR;
        end else if (stall) begin
            main_op_s = SLOT_HOLD;
        end else if (in_fire_s) begin
            main_op_s = SLOT_LOAD;
        end else if (out_fire_s) begin
            main_op_s = SLOT_DROP;
        end else begin
            main_op_s = SLOT_HOLD;
        end
    end

`endif

    // Stall counter next state: clear wins over increment, saturates at all-ones.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (cnt_clr) begin
            stall_cycles_d = {CNT_W{1'b0}};
        end else if (stall && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= {CNT_W{1'b0}};
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = main_valid_s;
    assign out_data     = main_data_s;
    assign stall_cycles = stall_cycles_q;

endmodule
